// File: rtl/fifo_watermark_ctrl_pkg.sv
// Shared types and constants for the FIFO watermark controller slice.
package fifo_ctrl_pkg;

  // Controller state encoding; code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Write-data pattern selection.
  localparam int PAT_CONST = 0;
  localparam int PAT_INC   = 1;
  localparam int PAT_LFSR  = 2;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_watermark_ctrl_if.sv
// FIFO-side signal bundle: the controller is the master, the FIFO the slave.
interface fifo_watermark_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);

  logic [CNT_W-1:0]  fifo_words;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] fifo_data;

  modport master (
    input  fifo_words, fifo_full, fifo_empty,
    output wr_en, rd_en, fifo_data
  );

  modport slave (
    output fifo_words, fifo_full, fifo_empty,
    input  wr_en, rd_en, fifo_data
  );

endinterface : fifo_watermark_ctrl_if

// File: rtl/fifo_watermark_ctrl_pattern_gen.sv
// Write-data pattern register: constant, incrementing or Galois LFSR.
// The register only moves when the controller actually writes a word, so
// the sequence seen by the FIFO is gap-free across stalls and bursts.
module fifo_pattern_gen
  import fifo_ctrl_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              PATTERN_MODE = PAT_CONST,
  parameter logic [DATA_W-1:0] CONST_DATA = 8'hAA,
  parameter logic [DATA_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [DATA_W-1:0] LFSR_SEED  = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [DATA_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

  localparam logic [DATA_W-1:0] RESET_VAL =
    (PATTERN_MODE == PAT_CONST) ? CONST_DATA :
    (PATTERN_MODE == PAT_INC)   ? '0         : SEED_EFF;

  logic [DATA_W-1:0] data_next;

  // Next pattern value as a pure function of the current one.
  always_comb begin
    data_next = data;
    case (PATTERN_MODE)
      PAT_INC:  data_next = data + DATA_W'(1);
      PAT_LFSR: data_next = data[0] ? ((data >> 1) ^ LFSR_TAPS) : (data >> 1);
      default:  data_next = data;
    endcase
  end

  // Pattern register: load reset value, advance only on an accepted write.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= RESET_VAL;
    end else if (advance) begin
      data <= data_next;
    end
  end

endmodule : fifo_pattern_gen

// File: rtl/fifo_watermark_ctrl.sv
// Hysteretic FIFO traffic master: fills to HIGH_WM, drains to LOW_WM, repeats.
// Strobes decode the state combinationally and are gated by the FIFO flags.
module fifo_watermark_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                CNT_W        = 4,
  parameter int                HIGH_WM      = 5,
  parameter int                LOW_WM       = 2,
  parameter int                PATTERN_MODE = PAT_CONST,
  parameter logic [DATA_W-1:0] CONST_DATA   = 8'hAA,
  parameter logic [DATA_W-1:0] LFSR_TAPS    = 8'hB8,
  parameter logic [DATA_W-1:0] LFSR_SEED    = 8'h01,
  parameter int                STAT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  fifo_watermark_ctrl_if.master fifo,
  output logic [1:0]          state_o,
  output logic [STAT_W-1:0]   wr_count,
  output logic [STAT_W-1:0]   rd_count
);

  // Reject watermark/mode combinations that cannot work at elaboration time.
  if (!(LOW_WM < HIGH_WM && HIGH_WM <= (1 << CNT_W) - 1)) begin : g_bad_wm
    $error("fifo_watermark_ctrl: need LOW_WM < HIGH_WM <= 2**CNT_W-1");
  end
  if (PATTERN_MODE < 0 || PATTERN_MODE > 2) begin : g_bad_mode
    $error("fifo_watermark_ctrl: PATTERN_MODE must be 0, 1 or 2");
  end

  // Watermarks sized to the occupancy bus so comparisons are width-matched.
  localparam logic [CNT_W-1:0] HIGH_WM_C = CNT_W'(HIGH_WM);
  localparam logic [CNT_W-1:0] LOW_WM_C  = CNT_W'(LOW_WM);

  state_t            state_q;
  state_t            state_d;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] pattern;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable low wins everywhere; watermarks give hysteresis.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = ST_IDLE;
    if (enable) begin
      case (state_q)
        ST_IDLE:  state_d = ST_FILL;
        ST_FILL:  state_d = (fifo.fifo_words >= HIGH_WM_C) ? ST_DRAIN : ST_FILL;
        ST_DRAIN: state_d = (fifo.fifo_words <= LOW_WM_C)  ? ST_FILL  : ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode: Moore strobes gated by the FIFO's full/empty flags.
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    case (state_q)
      ST_FILL:  wr_en = !fifo.fifo_full;
      ST_DRAIN: rd_en = !fifo.fifo_empty;
      default: begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
    endcase
  end

  assign fifo.wr_en     = wr_en;
  assign fifo.rd_en     = rd_en;
  assign fifo.fifo_data = pattern;
  assign state_o        = state_q;

  fifo_pattern_gen #(
    .DATA_W       (DATA_W),
    .PATTERN_MODE (PATTERN_MODE),
    .CONST_DATA   (CONST_DATA),
    .LFSR_TAPS    (LFSR_TAPS),
    .LFSR_SEED    (LFSR_SEED)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (wr_en),
    .data    (pattern)
  );

  // Transfer counters: free-running and wrapping; enable does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_en) wr_count <= wr_count + STAT_W'(1);
      if (rd_en) rd_count <= rd_count + STAT_W'(1);
    end
  end

endmodule : fifo_watermark_ctrl

// File: tb/tb_fifo_watermark_ctrl.sv
// Bench: three controllers (constant, incrementing, LFSR) each beside a
// 16-deep FIFO occupancy model, with an override path for directed flags.
module tb_fifo_watermark_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_FILL  = 1;
  localparam int S_DRAIN = 2;
  localparam int NDUT    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;

  // Directed override of the FIFO flags (applies to every instance).
  logic       ovr = 1'b0;
  logic [3:0] ovr_words = 4'd0;
  logic       ovr_full = 1'b0;
  logic       ovr_empty = 1'b1;
  logic       stall = 1'b0;

  int         occ [NDUT];
  logic [3:0] words_m [NDUT];
  logic       full_m  [NDUT];
  logic       empty_m [NDUT];

  logic [3:0]  words_v [NDUT];
  logic        full_v  [NDUT];
  logic        empty_v [NDUT];
  logic        wr_v    [NDUT];
  logic        rd_v    [NDUT];
  logic [7:0]  data_v  [NDUT];
  logic [1:0]  st_v    [NDUT];
  logic [15:0] wc_v    [NDUT];
  logic [15:0] rc_v    [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    fifo_watermark_ctrl_if #(.DATA_W(8), .CNT_W(4)) fif ();

    assign words_v[gi] = ovr ? ovr_words : words_m[gi];
    assign full_v[gi]  = ovr ? ovr_full  : full_m[gi];
    assign empty_v[gi] = ovr ? ovr_empty : empty_m[gi];
    assign fif.fifo_words = words_v[gi];
    assign fif.fifo_full  = full_v[gi];
    assign fif.fifo_empty = empty_v[gi];
    assign wr_v[gi]   = fif.wr_en;
    assign rd_v[gi]   = fif.rd_en;
    assign data_v[gi] = fif.fifo_data;

    fifo_watermark_ctrl #(.PATTERN_MODE(gi)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .fifo     (fif.master),
      .state_o  (st_v[gi]),
      .wr_count (wc_v[gi]),
      .rd_count (rc_v[gi])
    );
  end

  // FIFO flag view derived from the occupancy model.
  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      words_m[i] = (occ[i] > 15) ? 4'd15 : 4'(occ[i]);
      full_m[i]  = stall || (occ[i] >= 16);
      empty_m[i] = (occ[i] <= 0);
    end
  end

  // Occupancy updates one cycle after each accepted strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDUT; i++) occ[i] <= 0;
    end else begin
      for (int i = 0; i < NDUT; i++)
        occ[i] <= occ[i] + ((wr_v[i] && !full_v[i]) ? 1 : 0)
                         - ((rd_v[i] && !empty_v[i]) ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write data after n accepted writes since reset.
  function automatic logic [7:0] exp_data(input int mode, input int n);
    logic [7:0] p;
    case (mode)
      0: p = 8'hAA;
      1: p = 8'(n);
      default: begin
        p = 8'h01;
        repeat (n) p = p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
      end
    endcase
    return p;
  endfunction

  // Hysteresis rule from the controller's behaviour.
  function automatic int next_st(input int s, input bit en, input int w);
    if (!en) return S_IDLE;
    case (s)
      S_IDLE:  return S_FILL;
      S_FILL:  return (w >= 5) ? S_DRAIN : S_FILL;
      S_DRAIN: return (w <= 2) ? S_FILL : S_DRAIN;
      default: return S_IDLE;
    endcase
  endfunction

  task automatic do_reset(input bit en_after);
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    ovr = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    enable = en_after;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en;
    logic [3:0] w;
    bit         f;
    bit         e;
    int         st;
    bit         wr;
    bit         rd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [7:0] wq [NDUT][$];
    logic [7:0] lfsr_ref [6];
    int occ_min, occ_max;
    bit tracking, seen_drain1;
    int exp_st [NDUT];
    int exp_wc [NDUT];
    int exp_rc [NDUT];
    bit exp_wr, exp_rd;

    lfsr_ref = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

    //           en  words f  e  state    wr rd
    tbl[0]  = '{1, 4'd0,  0, 1, S_FILL,  1, 0};
    tbl[1]  = '{1, 4'd3,  1, 0, S_FILL,  0, 0};
    tbl[2]  = '{1, 4'd5,  0, 0, S_DRAIN, 0, 1};
    tbl[3]  = '{1, 4'd3,  0, 0, S_DRAIN, 0, 1};
    tbl[4]  = '{1, 4'd2,  0, 1, S_FILL,  1, 0};
    tbl[5]  = '{1, 4'd4,  0, 0, S_FILL,  1, 0};
    tbl[6]  = '{1, 4'd15, 1, 0, S_DRAIN, 0, 1};
    tbl[7]  = '{0, 4'd15, 1, 0, S_IDLE,  0, 0};
    tbl[8]  = '{0, 4'd0,  0, 1, S_IDLE,  0, 0};
    tbl[9]  = '{1, 4'd6,  0, 0, S_FILL,  1, 0};
    tbl[10] = '{1, 4'd6,  0, 0, S_DRAIN, 0, 1};
    tbl[11] = '{1, 4'd0,  0, 1, S_FILL,  1, 0};
    tbl[12] = '{1, 4'd2,  0, 0, S_FILL,  1, 0};
    tbl[13] = '{1, 4'd5,  0, 1, S_DRAIN, 0, 0};
    tbl[14] = '{1, 4'd3,  0, 0, S_DRAIN, 0, 1};

    // Free-running oscillation against the FIFO model, all three modes.
    do_reset(1'b1);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset_state[%0d]", i), 32'(st_v[i]), S_IDLE);
      check($sformatf("reset_wr_en[%0d]", i), 32'(wr_v[i]), 0);
      check($sformatf("reset_wr_count[%0d]", i), 32'(wc_v[i]), 0);
      check($sformatf("reset_rd_count[%0d]", i), 32'(rc_v[i]), 0);
      check($sformatf("reset_data[%0d]", i), 32'(data_v[i]), 32'(exp_data(i, 0)));
    end
    @(negedge clk); #1;
    check("idle_to_fill", 32'(st_v[0]), S_FILL);
    check("fill_data_const", 32'(data_v[0]), 32'h0AA);
    occ_min = 99; occ_max = -1; tracking = 0; seen_drain1 = 0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NDUT; i++) if (wr_v[i]) wq[i].push_back(data_v[i]);
      if (st_v[0] == 2'(S_DRAIN)) tracking = 1;
      if (tracking) begin
        if (occ[0] < occ_min) occ_min = occ[0];
        if (occ[0] > occ_max) occ_max = occ[0];
      end
      if (!seen_drain1 && st_v[1] == 2'(S_DRAIN)) begin
        seen_drain1 = 1;
        check("drain_hold_inc", 32'(data_v[1]), 32'h06);
      end
      @(negedge clk); #1;
    end
    check("occ_peak", occ_max, 6);
    check("occ_trough", occ_min, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("const_burst[%0d]", k), 32'(wq[0][k]), 32'h0AA);
      check($sformatf("inc_burst[%0d]", k), 32'(wq[1][k]), k);
      check($sformatf("lfsr_burst[%0d]", k), 32'(wq[2][k]), 32'(lfsr_ref[k]));
    end
    check("inc_second_burst", 32'(wq[1][6]), 32'h06);

    // Table of single-edge transitions on the constant-mode instance.
    do_reset(1'b0);
    ovr = 1'b1;
    #1;
    check("tbl_reset_state", 32'(st_v[0]), S_IDLE);
    for (int r = 0; r < 15; r++) begin
      enable    = tbl[r].en;
      ovr_words = tbl[r].w;
      ovr_full  = tbl[r].f;
      ovr_empty = tbl[r].e;
      @(negedge clk); #1;
      check($sformatf("tbl%0d_state", r), 32'(st_v[0]), tbl[r].st);
      check($sformatf("tbl%0d_wr_en", r), 32'(wr_v[0]), 32'(tbl[r].wr));
      check($sformatf("tbl%0d_rd_en", r), 32'(rd_v[0]), 32'(tbl[r].rd));
    end

    // Full stall during FILL: incrementing instance must hold.
    do_reset(1'b1);
    ovr = 1'b1; ovr_words = 4'd3; ovr_full = 1'b0; ovr_empty = 1'b0;
    @(negedge clk);
    ovr_full = 1'b1;
    #1;
    check("stall_wr_en", 32'(wr_v[1]), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("stall%0d_state", c), 32'(st_v[1]), S_FILL);
      check($sformatf("stall%0d_wr_en", c), 32'(wr_v[1]), 0);
      check($sformatf("stall%0d_data", c), 32'(data_v[1]), 0);
      check($sformatf("stall%0d_wr_count", c), 32'(wc_v[1]), 0);
    end
    ovr_full = 1'b0;
    #1;
    check("resume_wr_en", 32'(wr_v[1]), 1);
    @(negedge clk); #1;
    check("resume_data", 32'(data_v[1]), 1);
    check("resume_wr_count", 32'(wc_v[1]), 1);
    check("resume_state", 32'(st_v[1]), S_FILL);

    // Enable dropped in DRAIN, then re-enabled.
    do_reset(1'b1);
    ovr = 1'b1; ovr_words = 4'd0; ovr_full = 1'b0; ovr_empty = 1'b1;
    @(negedge clk);
    ovr_words = 4'd5; ovr_empty = 1'b0;
    @(negedge clk); #1;
    check("en_drop_pre_state", 32'(st_v[0]), S_DRAIN);
    check("en_drop_pre_rd_en", 32'(rd_v[0]), 1);
    enable = 1'b0;
    @(negedge clk); #1;
    check("en_drop_state", 32'(st_v[0]), S_IDLE);
    check("en_drop_rd_en", 32'(rd_v[0]), 0);
    check("en_drop_wr_en", 32'(wr_v[0]), 0);
    enable = 1'b1;
    @(negedge clk); #1;
    check("reen_state", 32'(st_v[0]), S_FILL);
    check("reen_wr_en", 32'(wr_v[0]), 1);
    @(negedge clk); #1;
    check("reen_drain", 32'(st_v[0]), S_DRAIN);
    check("reen_wr_count", 32'(wc_v[0]), 2);
    check("reen_rd_count", 32'(rc_v[0]), 1);

    // Asynchronous reset mid-FILL after three writes.
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("pre_rst_wr_count", 32'(wc_v[1]), 3);
    check("pre_rst_data", 32'(data_v[1]), 3);
    check("pre_rst_wr_en", 32'(wr_v[1]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", 32'(wr_v[1]), 0);
    check("async_rst_state", 32'(st_v[1]), S_IDLE);
    check("async_rst_wr_count", 32'(wc_v[1]), 0);
    check("async_rst_rd_count", 32'(rc_v[1]), 0);
    check("async_rst_data", 32'(data_v[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized enable and full stalls against the reference model.
    do_reset(1'b0);
    for (int i = 0; i < NDUT; i++) begin
      exp_st[i] = S_IDLE; exp_wc[i] = 0; exp_rc[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 15) != 0);
      stall  = ($urandom_range(0, 7) == 0);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        exp_wr = (exp_st[i] == S_FILL) && !full_v[i];
        exp_rd = (exp_st[i] == S_DRAIN) && !empty_v[i];
        check($sformatf("rnd_state[%0d]", i), 32'(st_v[i]), exp_st[i]);
        check($sformatf("rnd_wr_en[%0d]", i), 32'(wr_v[i]), 32'(exp_wr));
        check($sformatf("rnd_rd_en[%0d]", i), 32'(rd_v[i]), 32'(exp_rd));
        check($sformatf("rnd_data[%0d]", i), 32'(data_v[i]), 32'(exp_data(i, exp_wc[i])));
        check($sformatf("rnd_wr_count[%0d]", i), 32'(wc_v[i]), 32'(16'(exp_wc[i])));
        check($sformatf("rnd_rd_count[%0d]", i), 32'(rc_v[i]), 32'(16'(exp_rc[i])));
        if (exp_wr) exp_wc[i]++;
        if (exp_rd) exp_rc[i]++;
        exp_st[i] = next_st(exp_st[i], enable, int'(words_v[i]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_watermark_ctrl

// File: doc/fifo_watermark_ctrl.md
Name: fifo_watermark_ctrl

Overview:
Parametrised FIFO traffic controller with hysteresis. It fills an external synchronous FIFO until occupancy reaches a high watermark, then drains it until occupancy falls to a low watermark, and repeats. Write data comes from a selectable pattern generator: constant, incrementing or LFSR. It sits beside the FIFO as the stimulus/flow master and exposes state and transfer counters for debug.

Parameters:
DATA_W, 8, width of fifo_data and the pattern register
CNT_W, 4, width of fifo_words
HIGH_WM, 5, occupancy at or above which filling stops
LOW_WM, 2, occupancy at or below which draining stops
PATTERN_MODE, 0, 0 = constant, 1 = incrementing, 2 = Galois LFSR
CONST_DATA, 8'hAA, data value for mode 0
LFSR_TAPS, 8'hB8, Galois feedback mask for mode 2
LFSR_SEED, 8'h01, LFSR reset value for mode 2; a value of 0 is replaced by 1
STAT_W, 16, width of wr_count and rd_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  run request; low forces IDLE
fifo_words  in  CNT_W  current FIFO occupancy
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
wr_en  out  1  FIFO write strobe
fifo_data  out  DATA_W  write data (pattern register)
rd_en  out  1  FIFO read strobe
state_o  out  2  current state encoding
wr_count  out  STAT_W  accepted writes, wraps modulo 2^STAT_W
rd_count  out  STAT_W  issued reads, wraps modulo 2^STAT_W

Behaviour:
- Elaboration check: require LOW_WM < HIGH_WM <= 2^CNT_W-1 and PATTERN_MODE <= 2; otherwise $error.
- States: IDLE = 0, FILL = 1, DRAIN = 2. Code 3 is illegal and recovers to IDLE on the next edge.
- Reset (asynchronous): state = IDLE, wr_count = 0, rd_count = 0.
  - Pattern register resets to CONST_DATA (mode 0), 0 (mode 1) or LFSR_SEED (mode 2).
  - wr_en and rd_en fall to 0 immediately, in the same instant as rst_n, because they decode the state combinationally.
- Transitions, all evaluated at the rising edge; enable = 0 has top priority in every state and gives IDLE.
  - IDLE -> FILL when enable = 1.
  - FILL -> DRAIN when fifo_words >= HIGH_WM; otherwise stay in FILL.
  - DRAIN -> FILL when fifo_words <= LOW_WM; otherwise stay in DRAIN.
- Outputs (combinational, Moore plus flag gating):
  - wr_en = (state == FILL) && !fifo_full
  - rd_en = (state == DRAIN) && !fifo_empty
- Pattern register advances only at an edge where wr_en = 1, and holds otherwise (IDLE, DRAIN, full-stall).
  - Mode 0: unchanged.
  - Mode 1: +1, wrapping from all-ones to 0.
  - Mode 2: next = lsb ? (p >> 1) ^ LFSR_TAPS : p >> 1.
- Counters: wr_count += 1 on each wr_en edge; rd_count += 1 on each rd_en edge. Both wrap and are not cleared by enable.
- Watermark overshoot is by design. With a FIFO whose occupancy updates one cycle after the strobe:
  - peak occupancy is HIGH_WM + 1;
  - trough occupancy is LOW_WM - 1.
- The pattern register is not reset on FILL re-entry; sequences continue across bursts and across enable toggles.

Decomposition:
- Package fifo_ctrl_pkg:
  - state encodings ST_IDLE, ST_FILL, ST_DRAIN;
  - mode constants PAT_CONST, PAT_INC, PAT_LFSR.
- Sub-module fifo_pattern_gen, parametrised by DATA_W, PATTERN_MODE, CONST_DATA, LFSR_TAPS and LFSR_SEED.
  - Inputs: clk, rst_n, advance.
  - Output: data.
- The FSM, strobe gating and counters stay in the top module.

Test Plan:
- Default params, 16-deep FIFO model, enable = 1 after reset -> IDLE for 1 cycle, then FILL with data 0xAA. 6 writes occur, then DRAIN; reads continue until occupancy reaches 1, then FILL again. Occupancy oscillates between 1 and 6.
- PATTERN_MODE = 1 -> first burst writes 00..05 and the second burst begins at 06. fifo_data holds 06 throughout DRAIN.
- PATTERN_MODE = 2, seed 0x01, taps 0xB8 -> data sequence 01, B8, 5C, 2E, 17, B3.
- FILL with fifo_words = 3 and fifo_full forced high for 4 cycles -> wr_en = 0, data and wr_count hold, state stays FILL. Writes resume once full drops.
- enable dropped in DRAIN with occupancy 5 -> IDLE at the next edge, rd_en = 0. Re-enable -> FILL for 1 cycle (1 write), then DRAIN.
- rst_n pulsed low mid-FILL in mode 1 after 3 writes -> wr_en drops asynchronously. Counters read 0, data reads 00 and state_o reads 0.
